// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the shared memory port
// and the mem_arbiter. The arbiter uses the slave view; the environment uses master.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    // Instruction-fetch requester
    logic                  im_req;
    logic [ADDR_WIDTH-1:0] im_addr;
    logic                  im_gnt;
    logic [DATA_WIDTH-1:0] im_r_data;

    // Data requester
    logic                  dm_rd;
    logic                  dm_wr;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_w_data;
    logic                  dm_gnt;
    logic [DATA_WIDTH-1:0] dm_r_data;

    // Shared memory port
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] mem_w_data;
    logic [DATA_WIDTH-1:0] mem_r_data;

    // Status
    logic                  busy;
    logic                  err;

    modport slave (
        input  im_req, im_addr, dm_rd, dm_wr, dm_addr, dm_w_data, mem_r_data,
        output im_gnt, im_r_data, dm_gnt, dm_r_data,
               mem_addr, mem_rd, mem_wr, mem_w_data, busy, err
    );

    modport master (
        output im_req, im_addr, dm_rd, dm_wr, dm_addr, dm_w_data, mem_r_data,
        input  im_gnt, im_r_data, dm_gnt, dm_r_data,
               mem_addr, mem_rd, mem_wr, mem_w_data, busy, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch, data access) in front of one memory
// port. Data side wins by default; a starvation counter forces an IM grant.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [3:0] LAT_LAST  = 4'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]            state_q,      state_d;
    logic                  arb_en_q,     arb_en_d;
    logic                  owner_dm_q,   owner_dm_d;
    logic                  op_wr_q,      op_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
    logic [3:0]            lat_cnt_q,    lat_cnt_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic [DATA_WIDTH-1:0] im_rdata_q,   im_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q,   dm_rdata_d;
    logic                  err_q,        err_d;

    logic dm_req;
    logic im_wins;

    assign dm_req  = bus.dm_rd | bus.dm_wr;
    assign im_wins = bus.im_req & (~dm_req | (starve_cnt_q == STARVE_LIM));

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        arb_en_d     = 1'b1;
        owner_dm_d   = owner_dm_q;
        op_wr_d      = op_wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        im_rdata_d   = im_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        err_d        = err_q;

        case (state_q)
            ST_IDLE: begin
                // arb_en_q stays low for the first cycle after reset release
                if (arb_en_q) begin
                    if (!bus.im_req || im_wins) begin
                        starve_cnt_d = 4'd0;
                    end else if (starve_cnt_q != STARVE_LIM) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end

                    if (bus.im_req || dm_req) begin
                        state_d    = ST_ACCESS;
                        lat_cnt_d  = 4'd0;
                        owner_dm_d = ~im_wins;
                        op_wr_d    = im_wins ? 1'b0 : bus.dm_wr;
                        addr_d     = im_wins ? bus.im_addr : bus.dm_addr;
                        wdata_d    = im_wins ? '0 : bus.dm_w_data;
                        if (!im_wins && bus.dm_rd && bus.dm_wr) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            ST_ACCESS: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = ST_RESP;
                    if (!op_wr_q) begin
                        if (owner_dm_q) dm_rdata_d = bus.mem_r_data;
                        else            im_rdata_d = bus.mem_r_data;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 4'd1;
                end
            end

            ST_RESP: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            arb_en_q     <= 1'b0;
            owner_dm_q   <= 1'b0;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_cnt_q    <= 4'd0;
            starve_cnt_q <= 4'd0;
            im_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q      <= state_d;
            arb_en_q     <= arb_en_d;
            owner_dm_q   <= owner_dm_d;
            op_wr_q      <= op_wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            im_rdata_q   <= im_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            err_q        <= err_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately
    assign bus.mem_rd     = (state_q == ST_ACCESS) & ~op_wr_q;
    assign bus.mem_wr     = (state_q == ST_ACCESS) &  op_wr_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_w_data = wdata_q;
    assign bus.im_gnt     = (state_q == ST_RESP) & ~owner_dm_q;
    assign bus.dm_gnt     = (state_q == ST_RESP) &  owner_dm_q;
    assign bus.im_r_data  = im_rdata_q;
    assign bus.dm_r_data  = dm_rdata_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// transaction loop checked against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW   = 8;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LAT(1), .STARVE_MAX(SMAX)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Memory contents: a fixed function of address, with 0x10 holding 0xBEEF
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 8'h10) return 16'hBEEF;
        return {a ^ 8'h5A, ~a};
    endfunction

    assign bus.mem_r_data  = mem_fn(bus.mem_addr);
    assign bus1.mem_r_data = mem_fn(bus1.mem_addr);

    // Reference model state
    int            starve;
    logic          exp_err;
    logic [DW-1:0] exp_im_data;
    logic [DW-1:0] exp_dm_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_strobes(input string tag, input logic b, input logic rd, input logic wr,
                                 input logic ig, input logic dg);
        check({tag, "_busy"},   bus.busy,   b);
        check({tag, "_mem_rd"}, bus.mem_rd, rd);
        check({tag, "_mem_wr"}, bus.mem_wr, wr);
        check({tag, "_im_gnt"}, bus.im_gnt, ig);
        check({tag, "_dm_gnt"}, bus.dm_gnt, dg);
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_im_r_data"}, bus.im_r_data, exp_im_data);
        check({tag, "_dm_r_data"}, bus.dm_r_data, exp_dm_data);
        check({tag, "_err"},       bus.err,       exp_err);
    endtask

    // Applies the arbitration rules to the currently driven requests
    task automatic predict(output logic win_im);
        logic dmr;
        dmr    = bus.dm_rd | bus.dm_wr;
        win_im = bus.im_req && (!dmr || starve == SMAX);
        if (!bus.im_req || win_im) starve = 0;
        else if (starve < SMAX)    starve = starve + 1;
        if (!win_im && bus.dm_rd && bus.dm_wr) exp_err = 1'b1;
        if (win_im)          exp_im_data = mem_fn(bus.im_addr);
        else if (!bus.dm_wr) exp_dm_data = mem_fn(bus.dm_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          win_im;
        logic          exp_dm_order [6];
        logic          exp_rd;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        int            waited;
        int            r;

        exp_dm_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        starve      = 0;
        exp_err     = 1'b0;
        exp_im_data = '0;
        exp_dm_data = '0;

        rst = 1'b0;
        bus.im_req  = 1'b0; bus.im_addr  = '0;
        bus.dm_rd   = 1'b0; bus.dm_wr    = 1'b0; bus.dm_addr  = '0; bus.dm_w_data  = '0;
        bus1.im_req = 1'b0; bus1.im_addr = '0;
        bus1.dm_rd  = 1'b0; bus1.dm_wr   = 1'b0; bus1.dm_addr = '0; bus1.dm_w_data = '0;
        #2 rst = 1'b1;
        step();
        step();

        // Reset state
        check_strobes("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_regs("reset");

        // Single IM read at 0x10, request raised together with reset release
        rst = 1'b0;
        bus.im_req  = 1'b1;
        bus.im_addr = 8'h10;
        step();
        check("lockout_busy", bus.busy, 1'b0);
        predict(win_im);
        step();
        check_strobes("im_rd_acc1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("im_rd_acc1_addr", bus.mem_addr, 8'h10);
        step();
        check_strobes("im_rd_acc2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("im_rd_acc2_addr", bus.mem_addr, 8'h10);
        step();
        check_strobes("im_rd_resp", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("im_rd_data", bus.im_r_data, 16'hBEEF);
        bus.im_req = 1'b0;
        step();
        check_strobes("im_rd_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // DM write
        bus.dm_wr = 1'b1; bus.dm_addr = 8'h20; bus.dm_w_data = 16'h1234;
        predict(win_im);
        for (int i = 0; i < LAT; i++) begin
            step();
            check_strobes("dm_wr_acc", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            check("dm_wr_addr",  bus.mem_addr,   8'h20);
            check("dm_wr_wdata", bus.mem_w_data, 16'h1234);
        end
        step();
        check_strobes("dm_wr_resp", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("dm_wr_r_data_kept", bus.dm_r_data, 16'h0000);
        check("dm_wr_err", bus.err, 1'b0);
        bus.dm_wr = 1'b0;
        step();

        // Illegal op: read and write together becomes a write and sets err
        bus.dm_rd = 1'b1; bus.dm_wr = 1'b1; bus.dm_addr = 8'h30; bus.dm_w_data = 16'h5555;
        predict(win_im);
        step();
        check_strobes("illegal_acc", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("illegal_wdata", bus.mem_w_data, 16'h5555);
        step();
        step();
        check_strobes("illegal_resp", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("illegal_err", bus.err, 1'b1);
        bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
        step();
        step();
        check("illegal_err_sticky", bus.err, 1'b1);

        // Both requesters held continuously: starvation bound forces IM on the fifth grant
        bus.im_req = 1'b1; bus.im_addr = 8'h44;
        bus.dm_rd  = 1'b1; bus.dm_addr = 8'h55;
        for (int g = 0; g < 6; g++) begin
            waited = 0;
            do begin
                step();
                waited++;
                check("starve_no_overlap", bus.im_gnt & bus.dm_gnt, 1'b0);
            end while (!(bus.im_gnt | bus.dm_gnt) && waited < 10);
            check("starve_latency", waited, (g == 0) ? 3 : 4);
            check("starve_owner_dm", bus.dm_gnt, exp_dm_order[g]);
            check("starve_owner_im", bus.im_gnt, !exp_dm_order[g]);
            predict(win_im);
            check_regs("starve");
        end
        bus.im_req = 1'b0; bus.dm_rd = 1'b0;
        step();

        // Randomized transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            check("rnd_idle_busy", bus.busy, 1'b0);
            if (!bus.im_req && $urandom_range(0, 1) == 1) begin
                bus.im_req  = 1'b1;
                bus.im_addr = AW'($urandom);
            end
            if (!(bus.dm_rd | bus.dm_wr) && $urandom_range(0, 2) != 0) begin
                r = $urandom_range(0, 15);
                bus.dm_rd     = (r < 8) || (r == 15);
                bus.dm_wr     = (r >= 8);
                bus.dm_addr   = AW'($urandom);
                bus.dm_w_data = DW'($urandom);
            end
            if (!bus.im_req && !(bus.dm_rd | bus.dm_wr)) begin
                starve = 0;
                step();
                continue;
            end
            exp_rd    = 1'b0;
            exp_wdata = bus.dm_w_data;
            predict(win_im);
            exp_rd   = win_im || !bus.dm_wr;
            exp_addr = win_im ? bus.im_addr : bus.dm_addr;
            for (int i = 0; i < LAT; i++) begin
                step();
                check_strobes("rnd_acc", 1'b1, exp_rd, !exp_rd, 1'b0, 1'b0);
                check("rnd_acc_addr", bus.mem_addr, exp_addr);
                if (!exp_rd) check("rnd_acc_wdata", bus.mem_w_data, exp_wdata);
            end
            step();
            check_strobes("rnd_resp", 1'b1, 1'b0, 1'b0, win_im, !win_im);
            check_regs("rnd_resp");
            if (win_im) bus.im_req = 1'b0;
            else begin bus.dm_rd = 1'b0; bus.dm_wr = 1'b0; end
            step();
        end

        // Reset during the second ACCESS cycle takes effect without a clock edge
        bus.im_req = 1'b0; bus.dm_rd = 1'b0; bus.dm_wr = 1'b0;
        step();
        starve = 0;
        bus.im_req = 1'b1; bus.im_addr = 8'h77;
        step();
        step();
        check("midrst_before_rd", bus.mem_rd, 1'b1);
        #1 rst = 1'b1;
        #1;
        exp_im_data = '0; exp_dm_data = '0; exp_err = 1'b0; starve = 0;
        check_strobes("midrst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_regs("midrst_async");
        bus.im_req = 1'b0;
        step();
        step();
        check_strobes("midrst_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();

        // MEM_LAT=1 instance: back-to-back IM reads spaced three cycles apart
        bus1.im_req = 1'b1; bus1.im_addr = 8'h00;
        step();
        check("lat1_a_rd",   bus1.mem_rd,   1'b1);
        check("lat1_a_addr", bus1.mem_addr, 8'h00);
        check("lat1_a_gnt0", bus1.im_gnt,   1'b0);
        step();
        check("lat1_a_gnt",  bus1.im_gnt,    1'b1);
        check("lat1_a_dm",   bus1.dm_gnt,    1'b0);
        check("lat1_a_data", bus1.im_r_data, 16'h5AFF);
        bus1.im_addr = 8'h01;
        step();
        check("lat1_gap_gnt",  bus1.im_gnt, 1'b0);
        check("lat1_gap_busy", bus1.busy,   1'b0);
        step();
        check("lat1_b_rd",   bus1.mem_rd,   1'b1);
        check("lat1_b_addr", bus1.mem_addr, 8'h01);
        check("lat1_b_gnt0", bus1.im_gnt,   1'b0);
        step();
        check("lat1_b_gnt",  bus1.im_gnt,    1'b1);
        check("lat1_b_data", bus1.im_r_data, 16'h5BFE);
        bus1.im_req = 1'b0;
        step();
        check("lat1_end_gnt",  bus1.im_gnt, 1'b0);
        check("lat1_end_busy", bus1.busy,   1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: address width of both requesters and the memory port.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: data width.
REQ-003 SHALL have parameter MEM_LAT, default 2 (legal range 1..15): cycles mem_rd/mem_wr are held per access.
REQ-004 SHALL have parameter STARVE_MAX, default 4 (legal range 1..15): maximum consecutive DM grants while im_req is pending.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port im_req, input, 1 bit: instruction-fetch read request.
REQ-008 SHALL have port im_addr, input, ADDR_WIDTH bits: fetch address.
REQ-009 SHALL have port im_gnt, output, 1 bit: one-cycle completion pulse for a fetch.
REQ-010 SHALL have port im_r_data, output, DATA_WIDTH bits: fetched word, held until the next IM completion.
REQ-011 SHALL have ports dm_rd and dm_wr, inputs, 1 bit each: data read request and data write request.
REQ-012 SHALL have port dm_addr, input, ADDR_WIDTH bits, and port dm_w_data, input, DATA_WIDTH bits: data address and write data.
REQ-013 SHALL have port dm_gnt, output, 1 bit: one-cycle completion pulse for a data access.
REQ-014 SHALL have port dm_r_data, output, DATA_WIDTH bits: read word, held until the next DM read completion.
REQ-015 SHALL have ports mem_addr (output, ADDR_WIDTH), mem_rd (output, 1), mem_wr (output, 1), mem_w_data (output, DATA_WIDTH) and mem_r_data (input, DATA_WIDTH): the single shared memory port.
REQ-016 SHALL have port busy, output, 1 bit: asserted when state is not IDLE.
REQ-017 SHALL have port err, output, 1 bit: sticky flag, set when dm_rd and dm_wr are both high at arbitration.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-019 SHALL, in IDLE, arbitrate on the current inputs with these rules:
- DM request = dm_rd|dm_wr.
- DM wins unless im_req=1 and starve_cnt==STARVE_MAX; IM wins otherwise.
- With no request, stay in IDLE.
REQ-020 SHALL, on a grant decision, latch owner, op, address and write data, clear the latency counter, and go to ACCESS on the next edge.
REQ-021 SHALL, in ACCESS, drive mem_addr/mem_w_data from the latched values and hold mem_rd (read) or mem_wr (write) high for exactly MEM_LAT cycles, then go to RESP.
REQ-022 SHALL capture mem_r_data into the owner's data register at the end of the final ACCESS cycle, for reads only.
REQ-023 SHALL, in RESP, pulse the owner's gnt for one cycle with its data register already updated, then return to IDLE.
REQ-024 SHALL keep mem_rd and mem_wr low outside ACCESS; mem_addr and mem_w_data are don't-care outside ACCESS.
REQ-025 SHALL give a request seen in IDLE at cycle T its gnt at cycle T+MEM_LAT+1; one access occupies MEM_LAT+2 cycles.
REQ-026 SHALL require requesters to hold req, address and write data stable until gnt and to update req on the edge ending the gnt cycle; the arbiter ignores input changes outside IDLE.
REQ-027 SHALL update starve_cnt only at arbitration:
- increment (saturating at STARVE_MAX) on a DM grant with im_req=1;
- clear on an IM grant or whenever im_req=0.
REQ-028 SHALL treat dm_rd=dm_wr=1 at arbitration as a write and set err.
REQ-029 SHALL never assert im_gnt and dm_gnt in the same cycle.
REQ-030 SHALL leave dm_r_data unchanged on a DM write.

Reset
REQ-031 SHALL, on rst high and asynchronously (including mid-ACCESS):
- force state to IDLE;
- drive mem_rd, mem_wr, im_gnt, dm_gnt, busy and err to 0;
- clear im_r_data, dm_r_data, starve_cnt, the latency counter and all latched request fields to 0.
REQ-032 SHALL not start an arbitration in the first cycle after rst deasserts; it arbitrates from the following cycle.

Verification
REQ-033 Single IM read: im_req=1, im_addr=0x10, mem_r_data=0xBEEF, MEM_LAT=2 -> mem_rd high 2 cycles at addr 0x10, im_gnt pulse 3 cycles after request, im_r_data=0xBEEF.
REQ-034 DM write: dm_wr=1, dm_addr=0x20, dm_w_data=0x1234 -> mem_wr high 2 cycles with those values, dm_gnt pulse, dm_r_data unchanged, err=0.
REQ-035 Simultaneous requests: im_req and dm_rd held continuously, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IM,DM...; no overlapping gnts.
REQ-036 Illegal op: dm_rd=dm_wr=1 -> write performed, err=1 and stays 1 until rst.
REQ-037 Reset mid-access: rst asserted during the second ACCESS cycle -> mem_rd/mem_wr drop in the same cycle with no clock edge needed, no gnt issued, busy=0, data registers=0.
REQ-038 MEM_LAT=1 back-to-back IM reads to 0x00 then 0x01 -> gnts spaced exactly 3 cycles apart with the correct data each.
